// File: rtl/ncc_stream_matcher.sv
`timescale 1ns/1ps
// ncc_stream_matcher: streaming N x N template correlator scoring one window row per beat and tracking the best candidate.
// Optional build macro NCC_ABS_SCORE_EN: rank candidates by score magnitude instead of signed score.
module ncc_stream_matcher #(
    parameter int N        = 16,
    parameter int PIX_W    = 8,
    parameter int DESC_PPW = 4,
    parameter int IDX_W    = 16,
    localparam int SCORE_W = 2*PIX_W + 1 + 2*$clog2(N)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        desc_valid,
    input  logic [DESC_PPW*PIX_W-1:0]   desc_data,
    output logic                        desc_ready,
    output logic                        desc_loaded,
    input  logic                        search_start,
    input  logic                        row_valid,
    input  logic [N*PIX_W-1:0]          row_data,
    output logic                        row_ready,
    input  logic                        cand_last,
    output logic                        score_valid,
    output logic signed [SCORE_W-1:0]   score,
    output logic signed [SCORE_W-1:0]   best_score,
    output logic [IDX_W-1:0]            best_idx,
    output logic                        result_valid
);

    localparam int NPIX   = N*N;
    localparam int NWORD  = NPIX / DESC_PPW;
    localparam int DW     = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam int RW     = $clog2(N);
    localparam int PROD_W = 2*PIX_W + 1;

    logic [NPIX*PIX_W-1:0]        desc_r;
    logic [DW-1:0]                dcnt_r;
    logic                         desc_loaded_r;
    logic [RW-1:0]                row_cnt_r;
    logic signed [PROD_W-1:0]     prod_r [N];
    logic                         s1_valid_r, s1_first_r, s1_last_r, s1_clast_r;
    logic signed [SCORE_W-1:0]    sum_r;
    logic                         s2_valid_r, s2_first_r, s2_last_r, s2_clast_r;
    logic signed [SCORE_W-1:0]    acc_r;
    logic                         s3_done_r, s3_clast_r;
    logic signed [SCORE_W-1:0]    score_r, best_score_r;
    logic                         score_valid_r, score_clast_r, best_valid_r, result_valid_r;
    logic [IDX_W-1:0]             cand_cnt_r, score_idx_r, best_idx_r;

    logic                         desc_fire_s, row_fire_s, pipe_busy_s;
    logic [RW-1:0]                row_idx_s, sel_s;
    logic [N*PIX_W-1:0]           desc_row_s;
    logic signed [PROD_W-1:0]     dpix_s [N];
    logic signed [PROD_W-1:0]     wpix_s [N];
    logic signed [PROD_W-1:0]     prod_s [N];
    logic signed [SCORE_W-1:0]    tree_s;
    logic                         better_s;

`ifdef NCC_ABS_SCORE_EN
    function automatic logic [SCORE_W-1:0] mag(input logic signed [SCORE_W-1:0] v);
        if (v[SCORE_W-1]) begin
            mag = SCORE_W'(-v);
        end else begin
            mag = SCORE_W'(v);
        end
    endfunction
`endif

    assign pipe_busy_s  = s1_valid_r | s2_valid_r | s3_done_r;
    assign desc_ready   = (row_cnt_r == '0) && !pipe_busy_s;
    assign row_ready    = desc_loaded_r && (dcnt_r == '0);
    assign desc_fire_s  = desc_valid && desc_ready;
    assign row_fire_s   = row_valid && row_ready;
    assign desc_loaded  = desc_loaded_r;
    assign score_valid  = score_valid_r;
    assign score        = score_r;
    assign best_score   = best_score_r;
    assign best_idx     = best_idx_r;
    assign result_valid = result_valid_r;

    // Row products: a row arriving with search_start is row 0 of the new search.
    always_comb begin
        row_idx_s  = search_start ? '0 : row_cnt_r;
        sel_s      = RW'(N-1) - row_idx_s;
        desc_row_s = desc_r[int'(sel_s)*(N*PIX_W) +: N*PIX_W];
        for (int c = 0; c < N; c++) begin
            dpix_s[c] = PROD_W'($signed(desc_row_s[(N-1-c)*PIX_W +: PIX_W]));
            wpix_s[c] = PROD_W'({1'b0, row_data[(N-1-c)*PIX_W +: PIX_W]});
            prod_s[c] = dpix_s[c] * wpix_s[c];
        end
        tree_s = '0;
        for (int c = 0; c < N; c++) begin
            tree_s = tree_s + SCORE_W'(prod_r[c]);
        end
        better_s = 1'b0;
        if (!best_valid_r) begin
            better_s = 1'b1;
        end else begin
`ifdef NCC_ABS_SCORE_EN
            better_s = mag(score_r) > mag(best_score_r);
`else
            better_s = score_r > best_score_r;
`endif
        end
    end

    // Template load: words shift in so pixel 0 ends up in the MSBs, matching row_data layout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_r        <= '0;
            dcnt_r        <= '0;
            desc_loaded_r <= 1'b0;
        end else if (desc_fire_s) begin
            desc_r <= (desc_r << (DESC_PPW*PIX_W)) | (NPIX*PIX_W)'(desc_data);
            if (dcnt_r == DW'(NWORD-1)) begin
                dcnt_r        <= '0;
                desc_loaded_r <= 1'b1;
            end else begin
                dcnt_r <= dcnt_r + DW'(1);
                if (dcnt_r == '0) begin
                    desc_loaded_r <= 1'b0;
                end
            end
        end
    end

    // Stage 1 and row counter; a new row is kept even when search_start flushes older stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_r  <= '0;
            prod_r     <= '{default: '0};
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_clast_r <= 1'b0;
        end else begin
            s1_valid_r <= row_fire_s;
            if (row_fire_s) begin
                prod_r     <= prod_s;
                s1_first_r <= (row_idx_s == '0);
                s1_last_r  <= (row_idx_s == RW'(N-1));
                s1_clast_r <= cand_last && (row_idx_s == RW'(N-1));
                row_cnt_r  <= (row_idx_s == RW'(N-1)) ? '0 : row_idx_s + RW'(1);
            end else if (search_start) begin
                row_cnt_r <= '0;
            end
        end
    end

    // Stage 2 adder tree and stage 3 accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r      <= '0;
            s2_valid_r <= 1'b0;
            s2_first_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_clast_r <= 1'b0;
            acc_r      <= '0;
            s3_done_r  <= 1'b0;
            s3_clast_r <= 1'b0;
        end else begin
            s2_valid_r <= s1_valid_r && !search_start;
            sum_r      <= tree_s;
            s2_first_r <= s1_first_r;
            s2_last_r  <= s1_last_r;
            s2_clast_r <= s1_clast_r;
            s3_done_r  <= s2_valid_r && s2_last_r && !search_start;
            s3_clast_r <= s2_clast_r;
            if (s2_valid_r && !search_start) begin
                acc_r <= s2_first_r ? sum_r : acc_r + sum_r;
            end
        end
    end

    // Score publish, candidate numbering and best-candidate tracking (ties keep the earlier one).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_r        <= '0;
            score_valid_r  <= 1'b0;
            score_idx_r    <= '0;
            score_clast_r  <= 1'b0;
            cand_cnt_r     <= '0;
            best_valid_r   <= 1'b0;
            best_score_r   <= '0;
            best_idx_r     <= '0;
            result_valid_r <= 1'b0;
        end else if (search_start) begin
            score_valid_r  <= 1'b0;
            result_valid_r <= 1'b0;
            cand_cnt_r     <= '0;
            best_valid_r   <= 1'b0;
            best_score_r   <= '0;
            best_idx_r     <= '0;
        end else begin
            score_valid_r  <= s3_done_r;
            result_valid_r <= score_valid_r && score_clast_r;
            if (s3_done_r) begin
                score_r       <= acc_r;
                score_idx_r   <= cand_cnt_r;
                score_clast_r <= s3_clast_r;
                cand_cnt_r    <= cand_cnt_r + IDX_W'(1);
            end
            if (score_valid_r && better_s) begin
                best_score_r <= score_r;
                best_idx_r   <= score_idx_r;
                best_valid_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ncc_stream_matcher.sv
`timescale 1ns/1ps
// Directed bench for ncc_stream_matcher at N=4, PIX_W=8, DESC_PPW=4; expected scores are hand-computed.
module tb_ncc_stream_matcher;
    localparam int N = 4, PIX_W = 8, DESC_PPW = 4, IDX_W = 16;
    localparam int SW = 2*PIX_W + 1 + 2*$clog2(N);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  desc_valid = 1'b0;
    logic [31:0]           desc_data = 32'h0;
    logic                  desc_ready, desc_loaded;
    logic                  search_start = 1'b0;
    logic                  row_valid = 1'b0;
    logic [31:0]           row_data = 32'h0;
    logic                  row_ready;
    logic                  cand_last = 1'b0;
    logic                  score_valid, result_valid;
    logic signed [SW-1:0]  score, best_score;
    logic [IDX_W-1:0]      best_idx;

    ncc_stream_matcher #(.N(N), .PIX_W(PIX_W), .DESC_PPW(DESC_PPW), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_data(desc_data),
        .desc_ready(desc_ready), .desc_loaded(desc_loaded), .search_start(search_start),
        .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready), .cand_last(cand_last),
        .score_valid(score_valid), .score(score), .best_score(best_score), .best_idx(best_idx),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic signed [SW-1:0] sc_q[$];
    int                   st_q[$];
    int                   rt_q[$];
    logic signed [SW-1:0] rb_q[$];
    logic [IDX_W-1:0]     ri_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (score_valid) begin
                sc_q.push_back(score);
                st_q.push_back(cyc);
            end
            if (result_valid) begin
                rt_q.push_back(cyc);
                rb_q.push_back(best_score);
                ri_q.push_back(best_idx);
            end
        end
    end

    typedef struct packed {
        logic               start;
        logic [127:0]       rows;
        logic               clast;
        logic signed [31:0] exp_score;
        logic signed [31:0] exp_best;
        logic [15:0]        exp_idx;
    } vec_t;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            desc_valid = 1'b0;
            row_valid = 1'b0;
            search_start = 1'b0;
            cand_last = 1'b0;
        end
    endtask

    task automatic load_word(input logic [31:0] d);
        int w;
        w = 0;
        @(negedge clk);
        row_valid = 1'b0;
        search_start = 1'b0;
        desc_valid = 1'b1;
        desc_data = d;
        while (!desc_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            bad++;
            total++;
            $display("FAIL desc_ready_timeout: desc_ready stayed 0, required 1");
        end
        @(posedge clk);
    endtask

    task automatic load_template(input logic [31:0] d);
        for (int i = 0; i < 4; i++) load_word(d);
        idle(1);
    endtask

    task automatic drive_row(input logic [31:0] d, input logic cl, input logic st, output int fc);
        @(negedge clk);
        desc_valid = 1'b0;
        row_valid = 1'b1;
        row_data = d;
        cand_last = cl;
        search_start = st;
        check("row_ready", row_ready, 1);
        fc = cyc + 1;
    endtask

    task automatic pop_score(input string nm, input longint exp_s, input int exp_c);
        if (sc_q.size() == 0) begin
            bad++;
            total++;
            $display("FAIL %s: no score_valid pulse, required score %0d", nm, exp_s);
        end else begin
            check({nm, "_score"}, sc_q.pop_front(), exp_s);
            check({nm, "_latency"}, st_q.pop_front(), exp_c);
        end
    endtask

    task automatic pop_result(input string nm, input longint exp_b, input longint exp_i, input int exp_c);
        if (rt_q.size() == 0) begin
            bad++;
            total++;
            $display("FAIL %s: no result_valid pulse, required best %0d idx %0d", nm, exp_b, exp_i);
        end else begin
            check({nm, "_best"}, rb_q.pop_front(), exp_b);
            check({nm, "_idx"}, ri_q.pop_front(), exp_i);
            check({nm, "_latency"}, rt_q.pop_front(), exp_c);
        end
    endtask

    task automatic clear_q();
        sc_q.delete(); st_q.delete(); rt_q.delete(); rb_q.delete(); ri_q.delete();
    endtask

    vec_t vecs [4];
    int   fire_c [4];
    int   fc, fc0, fc1;
    logic [127:0] rows_v;
    logic signed [31:0] exp_b;
    int   exp_i;

    initial begin
        vecs[0] = '{1'b1, {4{32'h02020202}}, 1'b1, 32'sd32, 32'sd32, 16'd0};
        vecs[1] = '{1'b1, {32'h04030201, 32'h0, 32'h0, 32'h0}, 1'b0, 32'sd10, 32'sd10, 16'd0};
        vecs[2] = '{1'b0, {32'h0A0A0A0A, 32'h0A000000, 32'h0, 32'h0}, 1'b0, 32'sd50, 32'sd50, 16'd1};
        vecs[3] = '{1'b0, {32'h0A0A0A0A, 32'h0A000000, 32'h0, 32'h0}, 1'b1, 32'sd50, 32'sd50, 16'd1};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_desc_ready", desc_ready, 1);
        check("rst_row_ready", row_ready, 0);
        check("rst_desc_loaded", desc_loaded, 0);
        check("rst_best_score", best_score, 0);
        check("rst_best_idx", best_idx, 0);
        check("rst_score_valid", score_valid, 0);
        check("rst_result_valid", result_valid, 0);

        load_template(32'h01010101);
        check("load_desc_loaded", desc_loaded, 1);
        check("load_row_ready", row_ready, 1);

        // Table-driven candidates
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].start && i > 0) idle(6);
            rows_v = vecs[i].rows;
            for (int r = 0; r < 4; r++) begin
                drive_row(rows_v[(3-r)*32 +: 32], (r == 3) ? vecs[i].clast : 1'b0,
                          (r == 0) ? vecs[i].start : 1'b0, fc);
            end
            fire_c[i] = fc;
        end
        idle(8);
        check("table_n_scores", sc_q.size(), 4);
        check("table_n_results", rt_q.size(), 2);
        for (int i = 0; i < 4; i++) begin
            pop_score($sformatf("vec%0d", i), vecs[i].exp_score, fire_c[i] + 3);
            if (vecs[i].clast) begin
                pop_result($sformatf("vec%0d_res", i), vecs[i].exp_best, vecs[i].exp_idx, fire_c[i] + 4);
            end
        end
        clear_q();

        // Negative score vs later positive score
        @(negedge clk);
        search_start = 1'b1;
        idle(1);
        load_template(32'hFFFFFFFF);
        for (int r = 0; r < 4; r++) drive_row(32'hFFFFFFFF, 1'b0, 1'b0, fc0);
        idle(6);
        load_template(32'h01010101);
        drive_row(32'h19191919, 1'b0, 1'b0, fc1);
        for (int r = 1; r < 4; r++) drive_row(32'h0, r == 3, 1'b0, fc1);
        idle(8);
`ifdef NCC_ABS_SCORE_EN
        exp_b = -32'sd4080;
        exp_i = 0;
`else
        exp_b = 32'sd100;
        exp_i = 1;
`endif
        pop_score("neg_cand", -4080, fc0 + 3);
        pop_score("pos_cand", 100, fc1 + 3);
        pop_result("neg_pos_res", exp_b, exp_i, fc1 + 4);
        clear_q();

        // Abort two rows, restart with search_start on the new row 0
        drive_row(32'h05050505, 1'b0, 1'b0, fc);
        drive_row(32'h05050505, 1'b0, 1'b0, fc);
        drive_row(32'h01010101, 1'b0, 1'b1, fc);
        drive_row(32'h01010101, 1'b0, 1'b0, fc);
        drive_row(32'h01010101, 1'b0, 1'b0, fc);
        drive_row(32'h01010101, 1'b1, 1'b0, fc);
        idle(8);
        check("abort_n_scores", sc_q.size(), 1);
        pop_score("abort", 16, fc + 3);
        pop_result("abort_res", 16, 0, fc + 4);
        clear_q();

        // Reset during descriptor word 2
        load_word(32'h01010101);
        load_word(32'h01010101);
        @(negedge clk);
        desc_valid = 1'b1;
        desc_data = 32'h01010101;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_desc_loaded", desc_loaded, 0);
        check("mid_rst_desc_ready", desc_ready, 1);
        check("mid_rst_row_ready", row_ready, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_best_score", best_score, 0);
        check("mid_rst_best_idx", best_idx, 0);
        idle(2);
        rst_n = 1'b1;
        clear_q();
        load_template(32'h01010101);
        check("reload_desc_loaded", desc_loaded, 1);
        for (int r = 0; r < 4; r++) drive_row(32'h02020202, r == 3, 1'b0, fc);
        idle(8);
        pop_score("reload", 32, fc + 3);
        pop_result("reload_res", 32, 0, fc + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required $finish");
        $fatal(1);
    end
endmodule

// File: doc/ncc_stream_matcher.md
# ncc_stream_matcher

Streaming, parametrised template correlator: stores one N×N signed descriptor patch and scores a stream of N×N candidate window patches, delivered one row per beat, by exact integer multiply-accumulate. It tracks the highest-scoring candidate in the current search and reports its score and index. It sits between the window-fetch stage and the match-selection logic in the vision pipeline, and supersedes the fixed 16×16 log-domain correlator with one that is width- and size-configurable and fully pipelined.

## Interface
Parameters:
- N, 16 — patch side length in pixels; N ≥ 2.
- PIX_W, 8 — pixel width. Descriptor pixels are signed two's complement; window pixels are unsigned.
- DESC_PPW, 4 — descriptor pixels per load word; N*N must be a multiple of DESC_PPW.
- IDX_W, 16 — candidate index width.
- Derived: SCORE_W = 2*PIX_W + 1 + 2*$clog2(N) (signed).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor word offered.
- desc_data  in  DESC_PPW*PIX_W  descriptor pixels, raster order; the lowest-indexed pixel is in the MSBs.
- desc_ready  out  1  descriptor word may be accepted.
- desc_loaded  out  1  a complete template is resident.
- search_start  in  1  single-cycle pulse that starts a new search.
- row_valid  in  1  window row offered.
- row_data  in  N*PIX_W  one window row; pixel 0 is in the MSBs.
- row_ready  out  1  row may be accepted.
- cand_last  in  1  marks the final candidate of the search; sampled with the candidate's row N-1.
- score_valid  out  1  single-cycle pulse: score holds a new candidate score.
- score  out  SCORE_W  score of the most recently completed candidate.
- best_score  out  SCORE_W  best score in the current search.
- best_idx  out  IDX_W  index of the best candidate.
- result_valid  out  1  single-cycle pulse: search complete; best_* are final.

## Operation
- Transfers happen on the rising edge where valid and ready are both high.
- Descriptor load:
  - A word counter runs 0 to N*N/DESC_PPW-1 and wraps to 0 after the last word.
  - Accepting word 0 clears desc_loaded. Accepting the last word sets it.
  - desc_ready = 1 only when the row counter is 0 and the MAC pipeline is empty.
- Row path (accepted when row_ready = desc_loaded && (desc word counter == 0)):
  - Stage 1: N signed products (descriptor × zero-extended window), registered.
  - Stage 2: adder-tree sum of the N products, registered.
  - Stage 3: accumulate. The first row of a candidate loads the accumulator; later rows add to it.
- A row counter runs 0 to N-1. Candidates may be issued back to back with no gaps; one row is accepted per cycle.
- When row N-1 reaches stage 3, the module loads score and pulses score_valid. The candidate counter then increments and wraps at 2^IDX_W.
- Best tracking, one cycle after score_valid:
  - If best_valid = 0 or score > best_score (signed), load best_score and best_idx and set best_valid.
  - On a tie, the earlier candidate is kept.
- result_valid pulses in the same cycle that the cand_last candidate's best update commits.
- cand_last is ignored on rows 0 to N-2.
- search_start:
  - Clears best_valid, best_score, best_idx, the candidate counter and the row counter.
  - Flushes in-flight pipeline stages; their score_valid and result_valid are suppressed.
  - A row accepted in the same cycle as search_start becomes row 0 of candidate 0 of the new search.
- desc_valid while desc_ready = 0 is held off; no word is lost.
- Arithmetic never overflows given SCORE_W.

## Timing
- Reset values:
  - desc_ready = 1; desc_loaded = 0; row_ready = 0.
  - score_valid, result_valid = 0.
  - score, best_score, best_idx = 0.
  - All counters 0; pipeline valid bits 0.
- Row N-1 accepted at edge t: score_valid at t+3; best update and result_valid at t+4.
- Throughput: one row per cycle; one candidate per N cycles.
- Reset asserted mid-operation returns every register to its reset value immediately, and the template is discarded.

## Configuration
- NCC_ABS_SCORE_EN defined: the best comparison uses |score| > |best_score|. best_score still holds the signed value.
- NCC_ABS_SCORE_EN undefined: plain signed comparison.
- The macro does not change any port.

## Test plan
Bench configuration: N=4, PIX_W=8, DESC_PPW=4.

- Reset -> desc_ready=1, row_ready=0, desc_loaded=0, best_score=0, all pulses 0.
- Load 4 words of 32'h01010101, then one candidate of rows all 8'd2 -> score=32, score_valid exactly 3 cycles after row 3.
- Three back-to-back candidates scoring 10, 50, 50, cand_last on the third -> best_score=50, best_idx=1, result_valid 4 cycles after the last row.
- Template all 8'hFF (-1), window all 8'd255 -> score=-4080. Then a candidate scoring +100: best_idx=1 without the macro; best_idx=0, best_score=-4080 with NCC_ABS_SCORE_EN.
- search_start after 2 rows of a candidate, then 4 rows of 8'd1 with template 8'h01 -> single score_valid with score=16, idx 0; no pulse for the aborted rows.
- Drop rst_n during descriptor word 2 -> desc_loaded=0 and all outputs at reset values on the same edge; a reload of 4 words then succeeds.
